// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - RV32 MEM stage: data-memory handshake, load/store formatting, MEM/WB register
module memory_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUD,
    input  logic [31:0] ALU_result,
    input  logic [31:0] data2,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        memory_read_enable,
    input  logic        memory_write_enable,
    input  logic        regwrite_enable,
    input  logic        mux3_select,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_out,
    output logic        regwrite_enable_out,
    output logic        misaligned,
    output logic        mem_timeout
);
    typedef enum logic {IDLE, WAIT} state_t;

    // Abort fires during the TIMEOUT_CYCLES-th cycle spent in WAIT
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, data2_q, data2_d, alud_q, alud_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        re_q, re_d, we_q, we_d, rwe_q, rwe_d, sel_q, sel_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic        rwe_out_q, rwe_out_d, mis_q, mis_d, tmo_q, tmo_d;

    logic [31:0] cur_addr, cur_data2, cur_alud;
    logic [2:0]  cur_f3;
    logic [4:0]  cur_rd;
    logic        cur_re, cur_we, cur_rwe, cur_sel;

    // Current access: live inputs in IDLE (store wins over load), captured copy in WAIT
    always_comb begin
        if (state_q == WAIT) begin
            cur_addr  = addr_q;  cur_data2 = data2_q; cur_alud = alud_q;
            cur_f3    = f3_q;    cur_rd    = rd_q;
            cur_re    = re_q;    cur_we    = we_q;
            cur_rwe   = rwe_q;   cur_sel   = sel_q;
        end else begin
            cur_addr  = ALU_result; cur_data2 = data2; cur_alud = ALUD;
            cur_f3    = funct3;     cur_rd    = rd;
            cur_re    = memory_read_enable & ~memory_write_enable;
            cur_we    = memory_write_enable;
            cur_rwe   = regwrite_enable; cur_sel = mux3_select;
        end
    end

    logic [1:0]  lane;
    logic [31:0] sh_b, sh_h, ld_val, st_wdata;
    logic [3:0]  st_be;
    logic        size_h, size_w, mis_c;

    // Load extraction/extension, store lane replication and alignment check
    always_comb begin
        lane = cur_addr[1:0];
        sh_b = mem_rdata >> {lane, 3'b000};
        sh_h = mem_rdata >> {lane[1], 4'b0000};
        case (cur_f3)
            3'b000:  ld_val = {{24{sh_b[7]}}, sh_b[7:0]};
            3'b001:  ld_val = {{16{sh_h[15]}}, sh_h[15:0]};
            3'b100:  ld_val = {24'b0, sh_b[7:0]};
            3'b101:  ld_val = {16'b0, sh_h[15:0]};
            default: ld_val = mem_rdata;
        endcase
        case (cur_f3)
            3'b000:  begin st_be = 4'b0001 << lane; st_wdata = {4{cur_data2[7:0]}};  end
            3'b001:  begin st_be = 4'b0011 << lane; st_wdata = {2{cur_data2[15:0]}}; end
            default: begin st_be = 4'b1111;         st_wdata = cur_data2;            end
        endcase
        if (cur_we) begin
            size_h = (cur_f3 == 3'b001);
            size_w = (cur_f3 != 3'b000) && (cur_f3 != 3'b001);
        end else begin
            size_h = (cur_f3[1:0] == 2'b01);
            size_w = cur_f3[1];
        end
        mis_c = (size_h & lane[0]) | (size_w & (lane != 2'b00));
    end

    logic req_rd, req_wr, stall_c, complete;

    // Handshake FSM next-state and MEM/WB next values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        stall_c   = 1'b0;
        complete  = 1'b0;
        wb_data_d = wb_data_q;
        rd_out_d  = rd_out_q;
        rwe_out_d = 1'b0;
        mis_d     = 1'b0;
        tmo_d     = 1'b0;
        addr_d = cur_addr; data2_d = cur_data2; alud_d = cur_alud; f3_d = cur_f3;
        rd_d   = cur_rd;   re_d    = cur_re;    we_d   = cur_we;   rwe_d = cur_rwe;
        sel_d  = cur_sel;
        if (state_q == IDLE) begin
            if (cur_re | cur_we) begin
                if (mis_c) begin
                    mis_d = 1'b1;
                end else begin
                    req_rd = cur_re;
                    req_wr = cur_we;
                    if (mem_ready) begin
                        complete = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = WAIT;
                        cnt_d   = 32'd0;
                    end
                end
            end else begin
                wb_data_d = ALUD;
                rd_out_d  = rd;
                rwe_out_d = regwrite_enable;
            end
        end else begin
            req_rd = cur_re;
            req_wr = cur_we;
            if (mem_ready) begin
                complete = 1'b1;
                state_d  = IDLE;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
                tmo_d   = 1'b1;
                state_d = IDLE;
            end else begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 32'd1;
            end
        end
        if (complete) begin
            wb_data_d = cur_sel ? ld_val : cur_alud;
            rd_out_d  = cur_rd;
            rwe_out_d = cur_rwe;
        end
    end

    // All state, captured access and MEM/WB registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;   cnt_q   <= '0;
            addr_q  <= '0;     data2_q <= '0; alud_q <= '0; f3_q <= '0; rd_q <= '0;
            re_q    <= 1'b0;   we_q    <= 1'b0; rwe_q <= 1'b0; sel_q <= 1'b0;
            wb_data_q <= '0;   rd_out_q <= '0; rwe_out_q <= 1'b0;
            mis_q   <= 1'b0;   tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q   <= cnt_d;
            addr_q  <= addr_d;  data2_q <= data2_d; alud_q <= alud_d; f3_q <= f3_d; rd_q <= rd_d;
            re_q    <= re_d;    we_q    <= we_d;    rwe_q  <= rwe_d;  sel_q <= sel_d;
            wb_data_q <= wb_data_d; rd_out_q <= rd_out_d; rwe_out_q <= rwe_out_d;
            mis_q   <= mis_d;   tmo_q   <= tmo_d;
        end
    end

    // Request and stall are forced low the instant reset is asserted
    assign mem_addr            = {cur_addr[31:2], 2'b00};
    assign mem_wdata           = st_wdata;
    assign mem_read            = ~reset & req_rd;
    assign mem_write           = ~reset & req_wr;
    assign mem_byte_en         = (~reset & req_wr) ? st_be : 4'b0000;
    assign stall               = ~reset & stall_c;
    assign wb_data             = wb_data_q;
    assign rd_out              = rd_out_q;
    assign regwrite_enable_out = rwe_out_q;
    assign misaligned          = mis_q;
    assign mem_timeout         = tmo_q;
endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - scoreboard bench for memory_access_stage
module tb_memory_access_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUD, ALU_result, data2, mem_rdata;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        memory_read_enable, memory_write_enable, regwrite_enable, mux3_select, mem_ready;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  mem_byte_en;
    logic        mem_read, mem_write, stall, regwrite_enable_out, misaligned, mem_timeout;
    logic [4:0]  rd_out;

    memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .ALUD(ALUD), .ALU_result(ALU_result), .data2(data2),
        .funct3(funct3), .rd(rd), .memory_read_enable(memory_read_enable),
        .memory_write_enable(memory_write_enable), .regwrite_enable(regwrite_enable),
        .mux3_select(mux3_select), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall), .wb_data(wb_data),
        .rd_out(rd_out), .regwrite_enable_out(regwrite_enable_out),
        .misaligned(misaligned), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rwe, mis, tmo, chk;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] alud, input logic [31:0] addr, input logic [31:0] d2,
                          input logic [2:0] f3, input logic [4:0] r, input logic re, input logic we,
                          input logic rwe, input logic sel);
        ALUD = alud; ALU_result = addr; data2 = d2; funct3 = f3; rd = r;
        memory_read_enable = re; memory_write_enable = we; regwrite_enable = rwe; mux3_select = sel;
    endtask

    task automatic push(input logic [31:0] wb, input logic [4:0] r, input logic rwe,
                        input logic mis, input logic tmo, input logic chk);
        exp_t e;
        e.wb = wb; e.rd = r; e.rwe = rwe; e.mis = mis; e.tmo = tmo; e.chk = chk;
        sb.push_back(e);
    endtask

    // Every edge produces one MEM/WB result; compare it against the oldest expectation
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq("wb_rwe", 32'(regwrite_enable_out), 32'(e.rwe));
            check_eq("wb_misaligned", 32'(misaligned), 32'(e.mis));
            check_eq("wb_timeout", 32'(mem_timeout), 32'(e.tmo));
            if (e.chk) begin
                check_eq("wb_data", wb_data, e.wb);
                check_eq("wb_rd", 32'(rd_out), 32'(e.rd));
            end
        end
    end

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        set_in(32'h0, addr, 32'h0, f3, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        mem_rdata = rdata; mem_ready = 1'b1;
        #1;
        check_eq("ld_addr", mem_addr, addr & ~32'h3);
        check_eq("ld_read", 32'(mem_read), 32'd1);
        check_eq("ld_byte_en", 32'(mem_byte_en), 32'd0);
        check_eq("ld_stall", 32'(stall), 32'd0);
        push(exp, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d2,
                            input logic [3:0] be, input logic [31:0] wd, input logic also_read);
        set_in(32'h77, addr, d2, f3, 5'd0, also_read, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b1;
        #1;
        check_eq("st_byte_en", 32'(mem_byte_en), 32'(be));
        check_eq("st_wdata", mem_wdata, wd);
        check_eq("st_write", 32'(mem_write), 32'd1);
        check_eq("st_read", 32'(mem_read), 32'd0);
        push(32'h77, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        set_in(32'h0, 32'h100, 32'h0, 3'b010, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        mem_rdata = 32'h0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_mem_read", 32'(mem_read), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_rd_out", 32'(rd_out), 32'd0);
        check_eq("rst_rwe", 32'(regwrite_enable_out), 32'd0);
        check_eq("rst_pulses", 32'({misaligned, mem_timeout}), 32'd0);
        set_in(32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Plain ALU result
        set_in(32'h1234, 32'h0, 32'h0, 3'b000, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check_eq("alu_stall", 32'(stall), 32'd0);
        check_eq("alu_read", 32'(mem_read), 32'd0);
        push(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Single-cycle loads across sizes and lanes
        do_load(3'b000, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load(3'b000, 32'h100, 32'h0000_007F, 32'h0000_007F);
        do_load(3'b100, 32'h101, 32'h0000_9A00, 32'h0000_009A);
        do_load(3'b001, 32'h102, 32'h8001_0000, 32'hFFFF_8001);
        do_load(3'b101, 32'h100, 32'h1234_F00D, 32'h0000_F00D);
        do_load(3'b010, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load(3'b110, 32'h108, 32'h0123_4567, 32'h0123_4567);

        // Single-cycle stores; last one also has read enable set
        do_store(3'b000, 32'h101, 32'h1155, 4'b0010, 32'h5555_5555, 1'b0);
        do_store(3'b000, 32'h103, 32'h00AA, 4'b1000, 32'hAAAA_AAAA, 1'b0);
        do_store(3'b001, 32'h100, 32'h1234, 4'b0011, 32'h1234_1234, 1'b0);
        do_store(3'b010, 32'h104, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE, 1'b0);
        do_store(3'b010, 32'h10C, 32'h99, 4'b1111, 32'h0000_0099, 1'b1);

        // SH with memory busy for 3 cycles
        set_in(32'h77, 32'h102, 32'hABCD, 3'b001, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("sh_stall", 32'(stall), 32'd1);
            check_eq("sh_byte_en", 32'(mem_byte_en), 32'b1100);
            check_eq("sh_wdata", mem_wdata, 32'hABCD_ABCD);
            push(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        check_eq("sh_release", 32'(stall), 32'd0);
        check_eq("sh_write_done", 32'(mem_write), 32'd1);
        push(32'h77, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Misaligned LW
        set_in(32'h0, 32'h101, 32'h0, 3'b010, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        check_eq("mis_read", 32'(mem_read), 32'd0);
        check_eq("mis_stall", 32'(stall), 32'd0);
        push(32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        // Timeout: load never answered
        set_in(32'h0, 32'h200, 32'h0, 3'b010, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("to_stall", 32'(stall), 32'd1);
            check_eq("to_read", 32'(mem_read), 32'd1);
            push(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        #1;
        check_eq("to_abort_stall", 32'(stall), 32'd0);
        push(32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        set_in(32'h55, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("to_idle_read", 32'(mem_read), 32'd0);
        push(32'h55, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Reset in the middle of a WAIT
        set_in(32'h0, 32'h300, 32'h0, 3'b010, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        push(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_eq("rw_wait_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rw_rst_read", 32'(mem_read), 32'd0);
        check_eq("rw_rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        set_in(32'h0, 32'h400, 32'h0, 3'b010, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rw_idle_addr", mem_addr, 32'h400);
        check_eq("rw_idle_stall", 32'(stall), 32'd1);
        push(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        #1;
        check_eq("rw_done_stall", 32'(stall), 32'd0);
        push(32'h0BAD_F00D, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        set_in(32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
